// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control FSM
package ctrl_pkg;

   localparam int CTRL_STATE_W = 4;

   typedef enum logic [CTRL_STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps data-processing cmd/S bits to ALU op and flag-write requests
import ctrl_pkg::*;

module alu_decoder (
   input  logic       aluop,
   input  logic [5:0] funct,
   output logic [1:0] alucontrol,
   output logic [1:0] flagw
);

   logic supported;

   always_comb begin
      alucontrol = ALU_ADD;
      flagw      = 2'b00;
      supported  = 1'b0;
      if (aluop) begin
         supported = 1'b1;
         case (funct[4:1])
            CMD_ADD: alucontrol = ALU_ADD;
            CMD_SUB: alucontrol = ALU_SUB;
            CMD_AND: alucontrol = ALU_AND;
            CMD_ORR: alucontrol = ALU_ORR;
            default: supported  = 1'b0;
         endcase
         // Unknown commands still write back, but never touch the flags.
         if (supported) begin
            flagw[1] = funct[0];
            flagw[0] = funct[0] & ((alucontrol == ALU_ADD) | (alucontrol == ALU_SUB));
         end
      end
   end

endmodule

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - Moore control FSM for the multicycle ARM datapath
import ctrl_pkg::*;

module multicycle_main_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         op,
   input  logic [5:0]         funct,
   input  logic [3:0]         rd,
   output logic               pcs,
   output logic               regw,
   output logic               memw,
   output logic [1:0]         flagw,
   output logic               irwrite,
   output logic               nextpc,
   output logic               adrsrc,
   output logic [1:0]         resultsrc,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         alucontrol,
   output logic [1:0]         immsrc,
   output logic [1:0]         regsrc,
   output logic [STATE_W-1:0] state
);

   state_t state_q, state_d;
   logic   aluop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      pcs       = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      irwrite   = 1'b0;
      nextpc    = 1'b0;
      adrsrc    = 1'b0;
      resultsrc = RES_ALUOUT;
      alusrca   = 1'b0;
      alusrcb   = SRCB_RD2;
      aluop     = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrca   = 1'b1;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALU;
            irwrite   = 1'b1;
            nextpc    = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            alusrca   = 1'b1;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALU;
            case (op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrcb = SRCB_IMM;
            state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adrsrc  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc = RES_DATA;
            regw      = 1'b1;
            pcs       = (rd == 4'd15);
         end
         S_MEMWRITE: begin
            adrsrc = 1'b1;
            memw   = 1'b1;
         end
         S_EXECUTER: begin
            aluop   = 1'b1;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            aluop   = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regw = 1'b1;
            pcs  = (rd == 4'd15);
         end
         S_BRANCH: begin
            alusrcb   = SRCB_IMM;
            resultsrc = RES_ALU;
            pcs       = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol),
      .flagw      (flagw)
   );

   assign immsrc = op;
   assign regsrc = {op == OP_MEM, op == OP_BR};
   assign state  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - directed self-checking bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] op = 2'b11;
   logic [5:0] funct = 6'd0;
   logic [3:0] rd = 4'd0;
   logic       pcs, regw, memw, irwrite, nextpc, adrsrc, alusrca;
   logic [1:0] flagw, resultsrc, alusrcb, alucontrol, immsrc, regsrc;
   logic [3:0] state;

   multicycle_main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
      .pcs(pcs), .regw(regw), .memw(memw), .flagw(flagw),
      .irwrite(irwrite), .nextpc(nextpc), .adrsrc(adrsrc),
      .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .immsrc(immsrc), .regsrc(regsrc),
      .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcs;
      logic       regw;
      logic       memw;
      logic [1:0] flagw;
      logic       irw;
      logic       npc;
      logic       adr;
      logic [1:0] res;
      logic       sa;
      logic [1:0] sb;
      logic [1:0] alu;
   } rec_t;

   rec_t q[$];
   rec_t obs[0:4];
   int   passed = 0;
   int   total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   function automatic rec_t rec(input int s, input bit p, input bit rw, input bit mw,
                                input int fw, input bit iw, input bit np, input bit ad,
                                input int rs, input bit a, input int b, input int al);
      rec_t r;
      r.st = 4'(s);  r.pcs = p;  r.regw = rw; r.memw = mw; r.flagw = 2'(fw);
      r.irw = iw;    r.npc = np; r.adr = ad;  r.res = 2'(rs); r.sa = a;
      r.sb = 2'(b);  r.alu = 2'(al);
      return r;
   endfunction

   function automatic rec_t dut_rec();
      return rec(int'(state), pcs, regw, memw, int'(flagw), irwrite, nextpc, adrsrc,
                 int'(resultsrc), alusrca, int'(alusrcb), int'(alucontrol));
   endfunction

   // Expected per-cycle behaviour of one whole instruction, from its class.
   task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r, output int n);
      int  cmd = int'(f[4:1]);
      bit  s = f[0];
      bit  p15 = (r == 4'd15);
      bit  known = (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12);
      int  ctrl = (cmd == 2) ? 1 : (cmd == 0) ? 2 : (cmd == 12) ? 3 : 0;
      int  fw = known ? (s * 2 + ((s && ctrl < 2) ? 1 : 0)) : 0;
      q.push_back(rec(0, 0, 0, 0, 0, 1, 1, 0, 2, 1, 2, 0));
      q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
      n = 2;
      if (o == 2'b01) begin
         q.push_back(rec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         if (f[0]) begin
            q.push_back(rec(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
            q.push_back(rec(4, p15, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            n = 5;
         end else begin
            q.push_back(rec(5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
            n = 4;
         end
      end else if (o == 2'b00) begin
         q.push_back(rec(f[5] ? 7 : 6, 0, 0, 0, fw, 0, 0, 0, 0, 0, f[5] ? 1 : 0, ctrl));
         q.push_back(rec(8, p15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         n = 4;
      end else if (o == 2'b10) begin
         q.push_back(rec(9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
         n = 3;
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         chk($sformatf("cycle_state%0d", q[0].st), 32'(dut_rec()), 32'(q[0]));
         void'(q.pop_front());
         chk("imm_regsrc", {28'd0, immsrc, regsrc}, {28'd0, op, op == 2'b01, op == 2'b10});
      end
   end

   // Called at posedge+2 while in FETCH; returns at posedge+2 of the next FETCH.
   task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
      int n;
      op = o; funct = f; rd = r;
      for (int i = 0; i < 5; i++) obs[i] = '0;
      build(o, f, r, n);
      for (int i = 0; i < n; i++) begin
         obs[i] = dut_rec();
         @(posedge clk); #2;
      end
   endtask

   function automatic logic [31:0] seq();
      return {12'd0, obs[0].st, obs[1].st, obs[2].st, obs[3].st, obs[4].st};
   endfunction

   initial begin
      @(posedge clk); #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_fetch_strobes", {30'd0, irwrite, nextpc}, 32'd3);
      chk("rst_requests", {27'd0, pcs, regw, memw, flagw}, 32'd0);
      reset = 1'b0;

      run_instr(2'b00, 6'b001001, 4'd1);
      chk("adds_seq", seq(), 32'h01680);
      chk("adds_flagw_exec", 32'(obs[2].flagw), 32'd3);
      chk("adds_flagw_other", {26'd0, obs[0].flagw, obs[1].flagw, obs[3].flagw}, 32'd0);
      chk("adds_regw", {28'd0, obs[0].regw, obs[1].regw, obs[2].regw, obs[3].regw}, 32'b0001);
      chk("adds_pcs", 32'(obs[3].pcs), 32'd0);

      run_instr(2'b00, 6'b111001, 4'd2);
      chk("orrs_seq", seq(), 32'h01780);
      chk("orrs_exec", {26'd0, obs[2].sb, obs[2].alu, obs[2].flagw}, {26'd0, 6'b01_11_10});

      run_instr(2'b01, 6'b011001, 4'd15);
      chk("ldr_seq", seq(), 32'h01234);
      chk("ldr_adrsrc", 32'(obs[3].adr), 32'd1);
      chk("ldr_wb", {28'd0, obs[4].regw, obs[4].pcs, obs[4].res}, 32'b1101);

      run_instr(2'b01, 6'b011000, 4'd3);
      chk("str_seq", seq(), 32'h01250);
      chk("str_memw", {28'd0, obs[0].memw, obs[1].memw, obs[2].memw, obs[3].memw}, 32'b0001);

      run_instr(2'b10, 6'b000000, 4'd0);
      chk("b_seq", seq(), 32'h01900);
      chk("b_pcs", 32'(obs[2].pcs), 32'd1);

      run_instr(2'b11, 6'b111111, 4'd15);
      chk("und_seq", seq(), 32'h01000);
      chk("und_requests", {22'd0, obs[0].pcs, obs[0].regw, obs[0].memw, obs[0].flagw,
                           obs[1].pcs, obs[1].regw, obs[1].memw, obs[1].flagw}, 32'd0);

      run_instr(2'b00, 6'b011111, 4'd4);
      chk("unsup_seq", seq(), 32'h01680);
      chk("unsup_flagw", {28'd0, obs[2].flagw, obs[2].alu}, 32'd0);
      chk("unsup_regw", 32'(obs[3].regw), 32'd1);

      run_instr(2'b00, 6'b000001, 4'd5);
      run_instr(2'b00, 6'b100100, 4'd15);
      chk("sub_pc_pcs", 32'(obs[3].pcs), 32'd1);
      run_instr(2'b00, 6'b010101, 4'd6);

      op = 2'b01; funct = 6'b011000; rd = 4'd0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_str_state", 32'(state), 32'd5);
      chk("mid_str_memw", 32'(memw), 32'd1);
      reset = 1'b1;
      op = 2'b11;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_outs", {27'd0, memw, regw, pcs, irwrite, nextpc}, 32'b00011);
      @(posedge clk); #2;
      chk("held_rst_state", 32'(state), 32'd0);
      reset = 1'b0;
      @(posedge clk); #2;
      chk("release_decode", 32'(state), 32'd1);
      @(posedge clk); #2;
      chk("release_fetch", 32'(state), 32'd0);

      chk("model_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
